// File: rtl/order_msg_router.sv
// order_msg_router
// Pops 320-bit exchange message words from the ingress FIFO. Each word is decoded
// into a command for one of NUM_STOCKS per-stock order-book channels.
// The datapath has two stages:
//   s0      one decode register that holds a single command or a single drop
//   stage 1 one holding register per channel, which drives that channel's out_* slice
// Commands leave strictly in arrival order. A stalled channel therefore blocks every
// command queued behind it, whatever that command's target.
//
// stage | meaning
// s0    | one decoded word (command or drop) waiting to be routed
// ch[i] | command presented on channel i until out_ready[i]
module order_msg_router #(
    parameter int                         NUM_STOCKS = 4,
    parameter logic [NUM_STOCKS*32-1:0]   STOCK_IDS  = {32'd400, 32'd300, 32'd200, 32'd100},
    parameter int                         CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [319:0]              in_data,
    output logic                      in_ready,
    output logic [NUM_STOCKS-1:0]     out_valid,
    input  logic [NUM_STOCKS-1:0]     out_ready,
    output logic [NUM_STOCKS*32-1:0]  out_order_id,
    output logic [NUM_STOCKS*32-1:0]  out_quantity,
    output logic [NUM_STOCKS*64-1:0]  out_price,
    output logic [NUM_STOCKS*8-1:0]   out_side,
    output logic [NUM_STOCKS*3-1:0]   out_type,
    output logic [CNT_W-1:0]          cnt_accepted,
    output logic [CNT_W-1:0]          cnt_drop_stock,
    output logic [CNT_W-1:0]          cnt_drop_type
);

    localparam int IDX_W = (NUM_STOCKS > 1) ? $clog2(NUM_STOCKS) : 1;

    localparam logic [2:0] CMD_ADD = 3'b001;
    localparam logic [2:0] CMD_DEC = 3'b010;
    localparam logic [2:0] CMD_DEL = 3'b100;

    // Field extraction from the word at the FIFO head
    logic [7:0]  in_type_byte;
    logic [31:0] in_order_id;
    logic [31:0] in_stock_id;
    logic [7:0]  in_side;
    logic [31:0] in_quantity;
    logic [63:0] in_price;

    assign in_type_byte = in_data[319:312];
    assign in_order_id  = in_data[247:216];
    assign in_stock_id  = in_data[183:152];
    assign in_side      = in_data[151:144];
    assign in_quantity  = in_data[143:112];
    assign in_price     = in_data[111:48];

    logic [2:0]       dec_cmd;
    logic             dec_type_ok;
    logic             dec_hit;
    logic [IDX_W-1:0] dec_tgt;

    // Type decode
    always_comb begin
        dec_cmd     = 3'b000;
        dec_type_ok = 1'b1;
        case (in_type_byte)
            8'h53:   dec_cmd = CMD_ADD;
            8'h45:   dec_cmd = CMD_DEC;
            8'h44:   dec_cmd = CMD_DEL;
            default: dec_type_ok = 1'b0;
        endcase
    end

    // Stock match.
    // The scan runs from the top index down, so the lowest matching slot is the one
    // that finally lands in dec_tgt.
    always_comb begin
        dec_hit = 1'b0;
        dec_tgt = '0;
        for (int i = NUM_STOCKS - 1; i >= 0; i--) begin
            if (in_stock_id == STOCK_IDS[32*i +: 32]) begin
                dec_hit = 1'b1;
                dec_tgt = IDX_W'(i);
            end
        end
    end

    // Stage 0 state
    logic             s0_valid;
    logic             s0_drop_stock;
    logic             s0_drop_type;
    logic [IDX_W-1:0] s0_tgt;
    logic [2:0]       s0_cmd;
    logic [31:0]      s0_order_id;
    logic [31:0]      s0_quantity;
    logic [63:0]      s0_price;
    logic [7:0]       s0_side;

    // Stage 1 state
    logic [NUM_STOCKS-1:0] ch_valid;
    logic [31:0]           ch_order_id [NUM_STOCKS];
    logic [31:0]           ch_quantity [NUM_STOCKS];
    logic [63:0]           ch_price    [NUM_STOCKS];
    logic [7:0]            ch_side     [NUM_STOCKS];
    logic [2:0]            ch_cmd      [NUM_STOCKS];

    logic s0_drop;
    logic s0_advance;
    logic pop;

    assign s0_drop = s0_drop_stock | s0_drop_type;

    // s0 can move on when it holds a drop, or when its target register is free or
    // draining in this cycle. in_ready therefore depends combinationally on out_ready.
    assign s0_advance = s0_valid &&
                        (s0_drop || !ch_valid[s0_tgt] || out_ready[s0_tgt]);
    assign in_ready   = resetn && (!s0_valid || s0_advance);
    assign pop        = in_valid && in_ready;

    // Decode register: loads on a pop, empties when it advances without a reload
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_valid      <= 1'b0;
            s0_drop_stock <= 1'b0;
            s0_drop_type  <= 1'b0;
            s0_tgt        <= '0;
            s0_cmd        <= 3'b000;
            s0_order_id   <= '0;
            s0_quantity   <= '0;
            s0_price      <= '0;
            s0_side       <= '0;
        end else if (pop) begin
            s0_valid      <= 1'b1;
            s0_drop_type  <= !dec_type_ok;
            // A word that fails both checks is counted only as a type drop.
            s0_drop_stock <= dec_type_ok && !dec_hit;
            s0_tgt        <= dec_tgt;
            s0_cmd        <= dec_cmd;
            s0_order_id   <= in_order_id;
            s0_quantity   <= in_quantity;
            s0_price      <= in_price;
            s0_side       <= in_side;
        end else if (s0_advance) begin
            s0_valid      <= 1'b0;
        end
    end

    // Channel holding registers.
    // A register reloads from s0 or clears on a consumer handshake. Its payload is
    // left untouched when it clears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ch_valid <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                ch_order_id[i] <= '0;
                ch_quantity[i] <= '0;
                ch_price[i]    <= '0;
                ch_side[i]     <= '0;
                ch_cmd[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_STOCKS; i++) begin
                if (s0_advance && !s0_drop && (s0_tgt == IDX_W'(i))) begin
                    ch_valid[i]    <= 1'b1;
                    ch_order_id[i] <= s0_order_id;
                    ch_quantity[i] <= s0_quantity;
                    ch_price[i]    <= s0_price;
                    ch_side[i]     <= s0_side;
                    ch_cmd[i]      <= s0_cmd;
                end else if (ch_valid[i] && out_ready[i]) begin
                    ch_valid[i]    <= 1'b0;
                end
            end
        end
    end

    // Saturating statistics counters, bumped as s0 advances
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_accepted   <= '0;
            cnt_drop_stock <= '0;
            cnt_drop_type  <= '0;
        end else if (s0_advance) begin
            if (!s0_drop && (cnt_accepted != '1))
                cnt_accepted <= cnt_accepted + CNT_W'(1);
            if (s0_drop_stock && (cnt_drop_stock != '1))
                cnt_drop_stock <= cnt_drop_stock + CNT_W'(1);
            if (s0_drop_type && (cnt_drop_type != '1))
                cnt_drop_type <= cnt_drop_type + CNT_W'(1);
        end
    end

    assign out_valid = ch_valid;

    // Pack the per-channel registers onto the flat output buses
    always_comb begin
        out_order_id = '0;
        out_quantity = '0;
        out_price    = '0;
        out_side     = '0;
        out_type     = '0;
        for (int i = 0; i < NUM_STOCKS; i++) begin
            out_order_id[32*i +: 32] = ch_order_id[i];
            out_quantity[32*i +: 32] = ch_quantity[i];
            out_price[64*i +: 64]    = ch_price[i];
            out_side[8*i +: 8]       = ch_side[i];
            out_type[3*i +: 3]       = ch_cmd[i];
        end
    end

endmodule

// File: tb/tb_order_msg_router.sv
// Directed bench for order_msg_router.
// A second instance with 4-bit counters shares all inputs. It exercises counter
// saturation.
module tb_order_msg_router;

    logic          clk;
    logic          resetn;
    logic          in_valid;
    logic [319:0]  in_data;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [127:0]  out_order_id;
    logic [127:0]  out_quantity;
    logic [255:0]  out_price;
    logic [31:0]   out_side;
    logic [11:0]   out_type;
    logic [15:0]   cnt_accepted;
    logic [15:0]   cnt_drop_stock;
    logic [15:0]   cnt_drop_type;

    logic          s_in_ready;
    logic [3:0]    s_out_valid;
    logic [127:0]  s_out_order_id;
    logic [127:0]  s_out_quantity;
    logic [255:0]  s_out_price;
    logic [31:0]   s_out_side;
    logic [11:0]   s_out_type;
    logic [3:0]    s_cnt_accepted;
    logic [3:0]    s_cnt_drop_stock;
    logic [3:0]    s_cnt_drop_type;

    int n_total = 0;
    int n_pass  = 0;

    order_msg_router #(.NUM_STOCKS(4), .STOCK_IDS({32'd400, 32'd300, 32'd200, 32'd100}), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_order_id(out_order_id),
        .out_quantity(out_quantity), .out_price(out_price), .out_side(out_side), .out_type(out_type),
        .cnt_accepted(cnt_accepted), .cnt_drop_stock(cnt_drop_stock), .cnt_drop_type(cnt_drop_type)
    );

    order_msg_router #(.NUM_STOCKS(4), .STOCK_IDS({32'd400, 32'd300, 32'd200, 32'd100}), .CNT_W(4)) dut_s (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_order_id(s_out_order_id),
        .out_quantity(s_out_quantity), .out_price(s_out_price), .out_side(s_out_side), .out_type(s_out_type),
        .cnt_accepted(s_cnt_accepted), .cnt_drop_stock(s_cnt_drop_stock), .cnt_drop_type(s_cnt_drop_type)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a message word. Ignored bits carry a filler pattern, so they must not
    // leak into the decoded command.
    function automatic logic [319:0] mk(input logic [7:0] t, input logic [31:0] oid,
                                        input logic [31:0] sid, input logic [7:0] sd,
                                        input logic [31:0] q, input logic [63:0] p);
        logic [319:0] w;
        w          = {10{32'hA5A5_5A5A}};
        w[319:312] = t;
        w[247:216] = oid;
        w[183:152] = sid;
        w[151:144] = sd;
        w[143:112] = q;
        w[111:48]  = p;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 4'h0;
        tick(); tick();
        n_total++; if (out_valid !== 4'h0) $display("FAIL reset_out_valid got %h exp 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else n_pass++;
        n_total++; if ({cnt_accepted, cnt_drop_stock, cnt_drop_type} !== 48'h0)
            $display("FAIL reset_counters got %h exp 0", {cnt_accepted, cnt_drop_stock, cnt_drop_type}); else n_pass++;
        n_total++; if (out_order_id !== 128'h0) $display("FAIL reset_payload got %h exp 0", out_order_id); else n_pass++;
        resetn = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    task automatic test_add();
        out_ready = 4'hF;
        in_valid  = 1'b1;
        in_data   = mk(8'h53, 32'h11, 32'd200, 8'h42, 32'd50, 64'h64);
        tick();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 4'h0) $display("FAIL add_latency1 got %h exp 0", out_valid); else n_pass++;
        tick();
        n_total++; if (out_valid !== 4'b0010) $display("FAIL add_valid got %h exp 2", out_valid); else n_pass++;
        n_total++; if (out_type[5:3] !== 3'b001) $display("FAIL add_type got %b exp 001", out_type[5:3]); else n_pass++;
        n_total++; if (out_order_id[63:32] !== 32'h11) $display("FAIL add_order got %h exp 11", out_order_id[63:32]); else n_pass++;
        n_total++; if (out_quantity[63:32] !== 32'd50) $display("FAIL add_qty got %0d exp 50", out_quantity[63:32]); else n_pass++;
        n_total++; if (out_price[127:64] !== 64'h64) $display("FAIL add_price got %h exp 64", out_price[127:64]); else n_pass++;
        n_total++; if (out_side[15:8] !== 8'h42) $display("FAIL add_side got %h exp 42", out_side[15:8]); else n_pass++;
        n_total++; if (cnt_accepted !== 16'd1) $display("FAIL add_cnt got %0d exp 1", cnt_accepted); else n_pass++;
        tick();
        n_total++; if (out_valid !== 4'h0) $display("FAIL add_clear got %h exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] sids [4];
        logic [3:0]  exp_v;
        sids[0] = 32'd100; sids[1] = 32'd200; sids[2] = 32'd300; sids[3] = 32'd400;
        out_ready = 4'hF;
        for (int j = 0; j < 4; j++) begin
            in_valid = 1'b1;
            in_data  = mk(8'h53, 32'h100 + j, sids[j], 8'h53, 32'd10 + j, 64'd1000 + j);
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d] got %b exp 1", j, in_ready); else n_pass++;
            tick();
            exp_v = (j >= 1) ? (4'b0001 << (j - 1)) : 4'b0000;
            n_total++; if (out_valid !== exp_v) $display("FAIL b2b_valid[%0d] got %h exp %h", j, out_valid, exp_v); else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 4'b1000) $display("FAIL b2b_valid_last got %h exp 8", out_valid); else n_pass++;
        n_total++; if (out_order_id[127:96] !== 32'h103) $display("FAIL b2b_order3 got %h exp 103", out_order_id[127:96]); else n_pass++;
        tick();
        n_total++; if (out_valid !== 4'h0) $display("FAIL b2b_drain got %h exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready = 4'b1110;
        in_valid  = 1'b1;
        in_data   = mk(8'h44, 32'd1, 32'd100, 8'h42, 32'd5, 64'd77);
        tick();
        in_data   = mk(8'h44, 32'd2, 32'd100, 8'h42, 32'd6, 64'd78);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_second_pop got %b exp 1", in_ready); else n_pass++;
        tick();
        in_data   = mk(8'h44, 32'd3, 32'd300, 8'h53, 32'd7, 64'd79);
        tick(); tick(); tick();
        n_total++; if (in_ready !== 1'b0) $display("FAIL bp_stall got %b exp 0", in_ready); else n_pass++;
        n_total++; if (out_valid !== 4'b0001) $display("FAIL bp_hold_valid got %h exp 1", out_valid); else n_pass++;
        n_total++; if (out_order_id[31:0] !== 32'd1) $display("FAIL bp_hold_order got %0d exp 1", out_order_id[31:0]); else n_pass++;
        out_ready = 4'hF;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b exp 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 4'b0001) $display("FAIL bp_second_valid got %h exp 1", out_valid); else n_pass++;
        n_total++; if (out_order_id[31:0] !== 32'd2) $display("FAIL bp_second_order got %0d exp 2", out_order_id[31:0]); else n_pass++;
        tick();
        n_total++; if (out_valid !== 4'b0100) $display("FAIL bp_third_valid got %h exp 4", out_valid); else n_pass++;
        n_total++; if (out_order_id[95:64] !== 32'd3) $display("FAIL bp_third_order got %0d exp 3", out_order_id[95:64]); else n_pass++;
        n_total++; if (out_type[8:6] !== 3'b100) $display("FAIL bp_third_type got %b exp 100", out_type[8:6]); else n_pass++;
        tick();
        n_total++; if (cnt_accepted !== 16'd8) $display("FAIL bp_cnt got %0d exp 8", cnt_accepted); else n_pass++;
    endtask

    task automatic test_drops();
        logic [7:0]  types [3];
        logic [31:0] sids  [3];
        types[0] = 8'h53; sids[0] = 32'd999;
        types[1] = 8'h58; sids[1] = 32'd100;
        types[2] = 8'h58; sids[2] = 32'd999;
        out_ready = 4'hF;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_data  = mk(types[j], 32'd50 + j, sids[j], 8'h42, 32'd1, 64'd1);
            #1;
            n_total++; if (in_ready !== 1'b1) $display("FAIL drop_in_ready[%0d] got %b exp 1", j, in_ready); else n_pass++;
            tick();
            n_total++; if (out_valid !== 4'h0) $display("FAIL drop_valid[%0d] got %h exp 0", j, out_valid); else n_pass++;
        end
        in_valid = 1'b0;
        tick(); tick();
        n_total++; if (out_valid !== 4'h0) $display("FAIL drop_valid_end got %h exp 0", out_valid); else n_pass++;
        n_total++; if (cnt_drop_stock !== 16'd1) $display("FAIL drop_stock_cnt got %0d exp 1", cnt_drop_stock); else n_pass++;
        n_total++; if (cnt_drop_type !== 16'd2) $display("FAIL drop_type_cnt got %0d exp 2", cnt_drop_type); else n_pass++;
        n_total++; if (cnt_accepted !== 16'd8) $display("FAIL drop_acc_cnt got %0d exp 8", cnt_accepted); else n_pass++;
    endtask

    task automatic test_saturation();
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int j = 0; j < 20; j++) begin
            in_data = mk(8'h53, 32'd200 + j, 32'd12345, 8'h42, 32'd1, 64'd1);
            tick();
            if (j == 10) begin
                n_total++; if (s_cnt_drop_stock !== 4'd11) $display("FAIL sat_mid got %0d exp 11", s_cnt_drop_stock); else n_pass++;
            end
        end
        in_valid = 1'b0;
        tick();
        n_total++; if (s_cnt_drop_stock !== 4'd15) $display("FAIL sat_hold got %0d exp 15", s_cnt_drop_stock); else n_pass++;
        n_total++; if (cnt_drop_stock !== 16'd21) $display("FAIL sat_wide got %0d exp 21", cnt_drop_stock); else n_pass++;
        n_total++; if (s_cnt_accepted !== 4'd8) $display("FAIL sat_acc got %0d exp 8", s_cnt_accepted); else n_pass++;
    endtask

    task automatic test_mid_reset();
        out_ready = 4'h0;
        in_valid  = 1'b1;
        in_data   = mk(8'h45, 32'd7, 32'd300, 8'h42, 32'd3, 64'd9);
        tick();
        in_data   = mk(8'h45, 32'd8, 32'd300, 8'h42, 32'd4, 64'd9);
        tick();
        in_valid  = 1'b0;
        tick();
        n_total++; if (out_valid !== 4'b0100) $display("FAIL mr_pre_valid got %h exp 4", out_valid); else n_pass++;
        n_total++; if (out_type[8:6] !== 3'b010) $display("FAIL mr_pre_type got %b exp 010", out_type[8:6]); else n_pass++;
        resetn = 1'b0;
        #1;
        n_total++; if (out_valid !== 4'h0) $display("FAIL mr_async_valid got %h exp 0", out_valid); else n_pass++;
        n_total++; if ({cnt_accepted, cnt_drop_stock, cnt_drop_type} !== 48'h0)
            $display("FAIL mr_counters got %h exp 0", {cnt_accepted, cnt_drop_stock, cnt_drop_type}); else n_pass++;
        n_total++; if (out_order_id !== 128'h0) $display("FAIL mr_payload got %h exp 0", out_order_id); else n_pass++;
        tick();
        resetn    = 1'b1;
        out_ready = 4'hF;
        tick();
        n_total++; if (out_valid !== 4'h0) $display("FAIL mr_no_stale got %h exp 0", out_valid); else n_pass++;
        in_valid = 1'b1;
        in_data  = mk(8'h53, 32'd9, 32'd400, 8'h42, 32'd11, 64'd22);
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL mr_in_ready got %b exp 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        tick();
        n_total++; if (out_valid !== 4'b1000) $display("FAIL mr_new_valid got %h exp 8", out_valid); else n_pass++;
        n_total++; if (out_order_id[127:96] !== 32'd9) $display("FAIL mr_new_order got %0d exp 9", out_order_id[127:96]); else n_pass++;
        n_total++; if (cnt_accepted !== 16'd1) $display("FAIL mr_new_cnt got %0d exp 1", cnt_accepted); else n_pass++;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_drops();
        test_saturation();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/order_msg_router.md
# order_msg_router

Parametrised successor to the single-stock order parser. It pops 320-bit exchange message words from the ingress FIFO and decodes type, order ID, stock ID, side, quantity and price. Each decoded command goes to one of NUM_STOCKS per-stock order-book channels, each with its own valid/ready handshake and a one-entry holding register. Unknown stocks and unknown message types are dropped and counted. The block sits between the ingress message FIFO and the per-stock order-book engines.

## Interface
- NUM_STOCKS, 4: number of output channels (1..16).
- STOCK_IDS, {32'd400,32'd300,32'd200,32'd100}: packed NUM_STOCKS*32-bit vector. Channel i serves the stock ID in bits [32*i+31:32*i].
- CNT_W, 16: width of the saturating statistics counters.
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  FIFO not empty.
- in_data  in  320  message word at the FIFO head.
- in_ready  out  1  pop strobe. A word is consumed on a cycle with in_valid && in_ready.
- out_valid  out  NUM_STOCKS  per-channel command valid.
- out_ready  in  NUM_STOCKS  per-channel consumer ready.
- out_order_id  out  NUM_STOCKS*32  per-channel order ID.
- out_quantity  out  NUM_STOCKS*32  per-channel quantity.
- out_price  out  NUM_STOCKS*64  per-channel price.
- out_side  out  NUM_STOCKS*8  per-channel side byte.
- out_type  out  NUM_STOCKS*3  per-channel command: 001 ADD, 010 DECREASE, 100 DELETE.
- cnt_accepted  out  CNT_W  number of commands written to a channel.
- cnt_drop_stock  out  CNT_W  number of words dropped for an unmatched stock ID.
- cnt_drop_type  out  CNT_W  number of words dropped for an unknown type.

## Operation
- Field map of in_data:
  - type [319:312]
  - order_id [247:216]
  - stock_id [183:152]
  - side [151:144]
  - quantity [143:112]
  - price [111:48]
  - All other bits are ignored.
- Type decode: 0x53 gives ADD; 0x45 gives DECREASE; 0x44 gives DELETE. Any other value is a type drop.
- Stage 0 (decode register):
  - On a pop, s0 captures the fields, the 3-bit command and the target channel index.
  - The target is the lowest index i whose STOCK_IDS slot equals stock_id. If no slot matches, the word is marked as a stock drop.
  - If a word is both an unknown type and an unmatched stock, it counts as a type drop only.
- Stage 1 (channel registers): one holding register per channel, which drives the out_* slice and out_valid[i].
- s0 advances at a clock edge when any of these holds:
  - s0 holds a drop; or
  - the target register is empty; or
  - out_valid[t] && out_ready[t] in that cycle.
- When s0 advances, it writes the target register, or it bumps the matching drop counter. s0 then either empties or reloads from a same-cycle pop.
- in_ready = resetn && (!s0_valid || s0_advance). This is combinational, from out_ready to in_ready.
- A channel register clears on out_valid[i] && out_ready[i], unless it is reloaded in the same cycle.
- Head-of-line blocking: a command for a stalled channel blocks all channels behind it. Commands are never reordered and never lost.
- Counters saturate at all-ones and never wrap. cnt_accepted increments on every channel write.
- Payload on out_* is stable while out_valid[i] && !out_ready[i].

## Timing
- Reset (async assert, sync release):
  - out_valid = 0, all out_* payloads = 0, counters = 0, s0 empty.
  - in_ready = 0 while resetn is low, and 1 in the first cycle after release.
- Latency: a word popped at edge E appears with out_valid high after edge E+1 (2 edges from pop to visible).
- Throughput: one word per cycle when targets are free or draining. Consecutive words to the same channel also sustain one per cycle if out_ready stays high.
- A drop occupies s0 for one cycle and never stalls.
- Reset mid-operation discards s0 and all channel registers immediately. There is no partial output.
- out_ready is ignored for a channel whose out_valid is low.

## Test plan
- Reset then ADD: word with type 0x53, stock 200, order 0x11, qty 50, price 0x64, side 0x42.
  - Required: out_valid[1] rises 2 edges after the pop, with type 001, fields exact and side 0x42.
  - Required: cnt_accepted = 1.
- Back-to-back: 4 words to stocks 100/200/300/400 with all out_ready = 1.
  - Required: in_ready stays high, with one pop per cycle.
  - Required: each channel pulses out_valid once, in order, on consecutive cycles.
- Backpressure: hold out_ready[0] = 0 and send two DELETE (0x44) words for stock 100, then one for stock 300.
  - Required: the first word is held in channel 0 and the second is held in s0.
  - Required: in_ready = 0 and the stock-300 word stays unpopped.
  - Release out_ready[0]: all three are delivered in order with no loss.
- Drops: send stock 999 with type 0x53, then stock 100 with type 0x58, then stock 999 with type 0x58.
  - Required: no out_valid, in_ready never deasserts.
  - Required: cnt_drop_stock = 1 and cnt_drop_type = 2.
- Saturation (CNT_W = 4): send 20 unknown-stock words.
  - Required: cnt_drop_stock holds at 15.
- Mid-flight reset: assert resetn low while channel 2 holds a DECREASE (0x45) and s0 is full.
  - Required: out_valid goes to 0 asynchronously and counters clear.
  - Required: after release, the first new word is delivered normally.
